// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
package loader_pkg;

    localparam int BYTES_PER_INSTR = 4;
    localparam int LEN_BYTES       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_COLLECT,
        ST_SETUP,
        ST_WRITE,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } loader_state_e;

    function automatic logic accepts_bytes(input loader_state_e s);
        return (s == ST_IDLE) || (s == ST_LEN_HI) || (s == ST_COLLECT) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - little-endian byte-to-word shifter with byte counter
module instr_assembler
    import loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o
);

    localparam int CW = $clog2(BYTES_PER_INSTR);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_INSTR - 1);

    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // word_o is the word including the byte arriving now, so the final byte
    // and the completed word are available in the same cycle.
    assign word_o       = {byte_i, word_q[WIDTH-1:8]};
    assign word_valid_o = byte_valid_i && (cnt_q == LAST_BYTE);

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (byte_valid_i) begin
            word_d = word_o;
            cnt_d  = (cnt_q == LAST_BYTE) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed, checksummed image into cpuCore instruction memory
module program_loader
    import loader_pkg::*;
#(
    parameter int XLEN               = 64,
    parameter int INSTRUCTION_LENGTH = XLEN / 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          rx_ready,
    input  logic                          reload,
    output logic                          dbg_wr_en,
    output logic [XLEN-1:0]               dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          core_rst,
    output logic                          load_done,
    output logic                          load_error
);

    localparam int CNT_W = 8 * LEN_BYTES;

    loader_state_e                 state_q, state_d;
    logic                          rx_ready_q, rx_ready_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [7:0]                    csum_q, csum_d;
    logic [XLEN-1:0]               next_addr_q, next_addr_d;
    logic [XLEN-1:0]               dbg_addr_q, dbg_addr_d;
    logic [INSTRUCTION_LENGTH-1:0] dbg_instr_q, dbg_instr_d;

    logic                          fire;
    logic                          restart;
    logic                          asm_valid;
    logic                          asm_word_valid;
    logic [INSTRUCTION_LENGTH-1:0] asm_word;
    logic [CNT_W-1:0]              len_full;

    assign fire      = rx_valid && rx_ready_q;
    assign restart   = reload && ((state_q == ST_RUN) || (state_q == ST_ERROR));
    assign asm_valid = fire && (state_q == ST_COLLECT);
    assign len_full  = {rx_data, count_q[7:0]};

    instr_assembler #(
        .WIDTH(INSTRUCTION_LENGTH)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (restart),
        .byte_valid_i(asm_valid),
        .byte_i      (rx_data),
        .word_o      (asm_word),
        .word_valid_o(asm_word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rx_ready_q  <= 1'b0;
            count_q     <= '0;
            csum_q      <= '0;
            next_addr_q <= '0;
            dbg_addr_q  <= '0;
            dbg_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            next_addr_q <= next_addr_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_instr_q <= dbg_instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (fire) state_d = ST_LEN_HI;
            ST_LEN_HI:  if (fire) state_d = (len_full == '0) ? ST_CHECK : ST_COLLECT;
            ST_COLLECT: if (asm_word_valid) state_d = ST_SETUP;
            ST_SETUP:   state_d = ST_WRITE;
            ST_WRITE:   state_d = (count_q == CNT_W'(1)) ? ST_CHECK : ST_COLLECT;
            ST_CHECK:   if (fire) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
            ST_RUN:     if (reload) state_d = ST_IDLE;
            ST_ERROR:   if (reload) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // The write address/word are captured on entry to SETUP and only advance
    // at the next SETUP, so they stay stable well after the strobe drops.
    always_comb begin
        count_d     = count_q;
        csum_d      = csum_q;
        next_addr_d = next_addr_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_instr_d = dbg_instr_q;
        if (restart) begin
            count_d     = '0;
            csum_d      = '0;
            next_addr_d = '0;
            dbg_addr_d  = '0;
            dbg_instr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE:   if (fire) count_d = CNT_W'(rx_data);
                ST_LEN_HI: if (fire) count_d = len_full;
                ST_COLLECT: begin
                    if (fire) csum_d = csum_q ^ rx_data;
                    if (asm_word_valid) begin
                        dbg_addr_d  = next_addr_q;
                        dbg_instr_d = asm_word;
                    end
                end
                ST_WRITE: begin
                    count_d     = count_q - CNT_W'(1);
                    next_addr_d = next_addr_q + XLEN'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_ready_d = accepts_bytes(state_d);
        dbg_wr_en  = 1'b0;
        core_rst   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state_q)
            ST_WRITE: dbg_wr_en = 1'b1;
            ST_RUN: begin
                core_rst  = 1'b0;
                load_done = 1'b1;
            end
            ST_ERROR: load_error = 1'b1;
            default: ;
        endcase
    end

    assign rx_ready  = rx_ready_q;
    assign dbg_addr  = dbg_addr_q;
    assign dbg_instr = dbg_instr_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    localparam int XLEN = 64;
    localparam int IL   = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            reload = 1'b0;
    logic            rx_ready;
    logic            dbg_wr_en;
    logic [XLEN-1:0] dbg_addr;
    logic [IL-1:0]   dbg_instr;
    logic            core_rst;
    logic            load_done;
    logic            load_error;

    program_loader #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .dbg_wr_en (dbg_wr_en),
        .dbg_addr  (dbg_addr),
        .dbg_instr (dbg_instr),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]      byte_q[$];
    logic [XLEN-1:0] exp_addr[$];
    logic [IL-1:0]   exp_instr[$];
    bit              model_ok;
    logic [7:0]      model_csum;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: parse the stream as the image format describes it.
    task automatic build_model();
        int n;
        logic [7:0] x;
        n = int'({byte_q[1], byte_q[0]});
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            int b;
            b = 2 + 4 * i;
            exp_addr.push_back(XLEN'(i));
            exp_instr.push_back({byte_q[b+3], byte_q[b+2], byte_q[b+1], byte_q[b]});
            for (int k = 0; k < 4; k++) x = x ^ byte_q[b+k];
        end
        model_csum = x;
        model_ok   = (byte_q[2 + 4 * n] == x);
    endtask

    task automatic send_stream(input bit gap);
        foreach (byte_q[i]) begin
            int t;
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = byte_q[i];
            t = 0;
            while (!rx_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) chk("rx_ready_timeout", t, 0);
            @(posedge clk);
            if (gap) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_outcome();
        int t;
        t = 0;
        while (!(load_done || load_error) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("outcome_timeout", (t >= 200), 0);
        chk("pending_writes", exp_addr.size(), 0);
        chk("load_done", load_done, model_ok);
        chk("load_error", load_error, !model_ok);
        chk("core_rst", core_rst, !model_ok);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_core_rst", core_rst, 1);
        chk("reload_done", load_done, 0);
        chk("reload_error", load_error, 0);
        chk("reload_addr", dbg_addr, 0);
        chk("reload_rx_ready", rx_ready, 1);
    endtask

    logic            prev_wr = 1'b0;
    logic [XLEN-1:0] prev_addr = '0;
    logic [IL-1:0]   prev_instr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_wr = 1'b0;
        end else begin
            chk("core_rst_vs_done", core_rst, !load_done);
            if (prev_wr) begin
                chk("wr_pulse_width", dbg_wr_en, 0);
                chk("addr_hold", dbg_addr, prev_addr);
                chk("instr_hold", dbg_instr, prev_instr);
            end
            if (dbg_wr_en) begin
                if (!prev_wr) begin
                    chk("setup_addr", prev_addr, dbg_addr);
                    chk("setup_instr", prev_instr, dbg_instr);
                end
                chk("write_expected", (exp_addr.size() != 0), 1);
                if (exp_addr.size() != 0) begin
                    chk("write_addr", dbg_addr, exp_addr.pop_front());
                    chk("write_instr", dbg_instr, exp_instr.pop_front());
                end
            end
            prev_wr    = dbg_wr_en;
            prev_addr  = dbg_addr;
            prev_instr = dbg_instr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_wr_en", dbg_wr_en, 0);
        chk("rst_addr", dbg_addr, 0);
        chk("rst_instr", dbg_instr, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_done", load_done, 0);
        chk("rst_error", load_error, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_rst", rx_ready, 1);

        // Four-instruction image, correct checksum
        byte_q = '{8'h04, 8'h00, 8'h23, 8'h30, 8'h31, 8'h00, 8'h0F, 8'h00, 8'h20, 8'h01,
                   8'h33, 8'h03, 8'h52, 8'h00, 8'h83, 8'h34, 8'h74, 8'h00, 8'hAD};
        build_model();
        chk("model_csum", model_csum, 8'hAD);
        chk("model_ok", model_ok, 1);
        chk("model_i0", exp_instr[0], 32'h00313023);
        chk("model_i1", exp_instr[1], 32'h0120000F);
        chk("model_i2", exp_instr[2], 32'h00520333);
        chk("model_i3", exp_instr[3], 32'h00743483);
        chk("model_a3", exp_addr[3], 3);
        send_stream(1'b0);
        wait_outcome();
        chk("t1_done", load_done, 1);
        chk("t1_core_rst", core_rst, 0);

        // Same image, checksum off by one
        do_reload();
        byte_q[18] = 8'hAC;
        build_model();
        chk("model_bad_ok", model_ok, 0);
        send_stream(1'b0);
        wait_outcome();
        chk("t2_error", load_error, 1);
        chk("t2_core_rst", core_rst, 1);
        chk("t2_done", load_done, 0);

        // Empty image
        do_reload();
        byte_q = '{8'h00, 8'h00, 8'h00};
        build_model();
        chk("model_empty_writes", exp_addr.size(), 0);
        send_stream(1'b0);
        wait_outcome();
        chk("t3_done", load_done, 1);

        // One instruction with rx_valid toggling every cycle
        do_reload();
        byte_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h83};
        build_model();
        chk("model_t4_i0", exp_instr[0], 32'h00100093);
        send_stream(1'b1);
        wait_outcome();
        chk("t4_done", load_done, 1);

        // Reset mid-load, then a fresh image
        do_reload();
        byte_q = '{8'h01, 8'h00, 8'h23, 8'h30};
        send_stream(1'b0);
        rst = 1'b0;
        #1;
        chk("abort_rx_ready", rx_ready, 0);
        chk("abort_wr_en", dbg_wr_en, 0);
        chk("abort_addr", dbg_addr, 0);
        chk("abort_instr", dbg_instr, 0);
        chk("abort_core_rst", core_rst, 1);
        @(negedge clk);
        rst = 1'b1;
        byte_q = '{8'h01, 8'h00, 8'h23, 8'h30, 8'h31, 8'h00, 8'h22};
        build_model();
        chk("model_t5_ok", model_ok, 1);
        send_stream(1'b0);
        wait_outcome();
        chk("t5_done", load_done, 1);

        // Reload from RUN, then a one-instruction image
        do_reload();
        byte_q = '{8'h01, 8'h00, 8'h0F, 8'h00, 8'h20, 8'h01, 8'h2E};
        build_model();
        chk("model_t6_i0", exp_instr[0], 32'h0120000F);
        send_stream(1'b0);
        wait_outcome();
        chk("t6_done", load_done, 1);
        chk("t6_core_rst", core_rst, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
